outputs_scatter_mcast: RTL and testbench
========================================

Name: outputs_scatter_mcast

Overview:
Parametrised successor to the broadcast output scatter stage. It takes one input beat carrying num_out_p lanes plus a per-lane destination mask. It enqueues each selected lane into its own els_p-deep output FIFO and reports per-lane occupancy. In decoupled mode, slow output lanes do not stall lanes that have already taken their data: a per-lane delivered mask tracks partial delivery. Sits between an accelerator compute array and its per-destination output links.

Parameters:
width_p, none (must be set), bits per lane.
num_out_p, none (must be set), number of output lanes.
els_p, 2, depth of each output FIFO; must be >= 2.
decoupled_p, 0, 0 = lockstep (all masked lanes enqueue in the same cycle); 1 = decoupled (lanes enqueue independently; beat retires when all masked lanes have taken it).
cnt_w_lp, `BSG_SAFE_CLOG2(els_p+1), occupancy counter width (localparam).

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
reset_i  in  1  synchronous, active-high reset.
v_i  in  1  input beat valid; data_i and mask_i held stable while v_i=1 until accepted.
data_i  in  num_out_p*width_p  per-lane payload; lane i is bits [i*width_p +: width_p].
mask_i  in  num_out_p  destination select; bit i=1 routes lane i to FIFO i.
ready_o  out  1  beat-accept strobe; qualified by v_i (never 1 when v_i=0); beat retires on the cycle with v_i & ready_o.
v_o  out  num_out_p  per-lane output valid.
data_o  out  num_out_p*width_p  per-lane FIFO head.
yumi_i  in  num_out_p  per-lane dequeue; legal only when the matching v_o bit is 1.
count_o  out  num_out_p*cnt_w_lp  per-lane FIFO occupancy, registered, 0..els_p.
pending_o  out  num_out_p  decoupled mode: lanes already delivered for the current beat (sent_r); tied to 0 when decoupled_p=0.

Behaviour:
- Reset, synchronous: all FIFOs empty; v_o=0; count_o=0; sent_r=0; pending_o=0. ready_o=0 while reset_i=1. Reset mid-beat discards partial delivery; upstream re-presents the beat.
- Lane can-accept: lane_rdy[i] = (count<els_p) | yumi_i[i]. A full FIFO may enqueue and dequeue in the same cycle.
- Enqueue-to-output latency is 1 cycle: a lane written at edge N shows v_o at N+1 if its FIFO was empty. No combinational path from data_i to data_o.
- Lockstep mode (decoupled_p=0):
  - ready_o = v_i & AND over i of (~mask_i[i] | lane_rdy[i]).
  - enq[i] = ready_o & mask_i[i].
  - No lane enqueues unless all masked lanes can accept.
- Decoupled mode (decoupled_p=1):
  - enq[i] = v_i & mask_i[i] & ~sent_r[i] & lane_rdy[i].
  - ready_o = v_i & AND over i of (~mask_i[i] | sent_r[i] | enq[i]).
  - Next sent_r: 0 if ready_o, else sent_r | enq.
  - Each lane is written at most once per beat. pending_o = sent_r.
- mask_i=0 with v_i=1: ready_o=1 in the same cycle; nothing is enqueued (drop beat).
- Counters: count[i] next = count[i] + enq[i] - yumi_i[i]. Simultaneous enq and yumi holds the count. Wrap-around of FIFO pointers at els_p-1 goes to 0.
- FIFO order per lane is strict FIFO. Lanes are independent; no ordering across lanes.
- Assertions (simulation only):
  - yumi_i[i] & ~v_o[i].
  - Change of data_i or mask_i while v_i & ~ready_o.
  - count[i] > els_p.

Test Plan:
- Lockstep broadcast (num_out_p=4, els_p=2, decoupled_p=0): mask=4'hF, data lanes 0xA0..0xA3, yumi_i=0 -> ready_o=1 on beats 1 and 2. Beat 3 gets ready_o=0. count_o=2 on every lane. v_o=4'hF one cycle after beat 1.
- Lockstep stall: lane 2 full, others empty, mask=4'hF -> ready_o=0 and no lane enqueues. Now pulse yumi_i[2] -> ready_o=1 that cycle, all four lanes enqueue, lane 2 count stays 2.
- Decoupled partial (decoupled_p=1): lane 3 full, mask=4'hF, beat 0xB0..0xB3 -> lanes 0-2 enqueue in cycle 0, pending_o=4'h7, ready_o=0. After yumi_i[3], lane 3 enqueues, ready_o=1, pending_o returns to 0. Each lane holds exactly one copy of the beat.
- Multicast mask: mask=4'b0101 -> only lanes 0 and 2 enqueue; count_o of lanes 1 and 3 stays 0. mask=0 -> ready_o=1 same cycle, no counts change.
- Full-pass: lane 0 at count=els_p with yumi_i[0]=1 and a new beat -> enqueue and dequeue in the same cycle; count stays els_p; head advances in order.
- Reset mid-beat: decoupled, pending_o=4'h3, assert reset_i one cycle -> pending_o=0, v_o=0, count_o=0. The same beat re-presented delivers to all four lanes.

Source files
------------

// File: rtl/outputs_scatter_mcast.sv
// -----------------------------------------------------------------------------
// outputs_scatter_mcast
//
// Purpose:
//   Multicast output scatter stage. One input beat carries num_out_p lanes and
//   a per-lane destination mask. Every selected lane is written into its own
//   els_p-deep output FIFO. Per-lane occupancy is reported. Two enqueue
//   policies are available:
//     decoupled_p = 0 : lockstep. All masked lanes are written in the same
//                       cycle, or none of them is written.
//     decoupled_p = 1 : decoupled. Each masked lane is written as soon as its
//                       FIFO has room. A delivered mask (sent_q) records which
//                       lanes already hold the current beat. The beat retires
//                       once every masked lane has taken it.
//   width_p and num_out_p have to be chosen by the instantiating design; the
//   defaults exist only so that the module elaborates on its own. els_p must
//   be at least 2.
//
// Ports:
//   clk_i      clock; all state changes on the rising edge
//   reset_i    synchronous, active-high reset
//   v_i        input beat valid
//   data_i     num_out_p lanes of width_p bits; lane i = [i*width_p +: width_p]
//   mask_i     destination select; bit i routes lane i to FIFO i
//   ready_o    beat-accept strobe (only ever 1 while v_i = 1)
//   v_o        per-lane output valid (FIFO not empty)
//   data_o     per-lane FIFO head
//   yumi_i     per-lane dequeue, legal only while the matching v_o bit is 1
//   count_o    per-lane registered occupancy, 0..els_p
//   pending_o  decoupled mode: lanes already delivered for the current beat
//
// Handshake (both sides):
//   Input: the producer raises v_i and holds data_i and mask_i stable until it
//   sees v_i & ready_o at a rising edge. That edge retires the beat. ready_o is
//   computed from the current inputs and FIFO state, and it is forced low
//   during reset.
//   Output: v_o[i] means FIFO i has a head entry on data_o. The consumer pulses
//   yumi_i[i] to take that entry at the next edge. yumi_i[i] is an
//   acknowledge, not a request: it must only be raised while v_o[i] = 1.
// -----------------------------------------------------------------------------
module outputs_scatter_mcast #(
  parameter int width_p     = 8,
  parameter int num_out_p   = 4,
  parameter int els_p       = 2,
  parameter bit decoupled_p = 1'b0,
  localparam int cnt_w_lp   = (els_p + 1 <= 2) ? 1 : $clog2(els_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  input  logic [num_out_p*width_p-1:0]  data_i,
  input  logic [num_out_p-1:0]          mask_i,
  output logic                          ready_o,
  output logic [num_out_p-1:0]          v_o,
  output logic [num_out_p*width_p-1:0]  data_o,
  input  logic [num_out_p-1:0]          yumi_i,
  output logic [num_out_p*cnt_w_lp-1:0] count_o,
  output logic [num_out_p-1:0]          pending_o
);

  localparam int ptr_w_lp = (els_p <= 2) ? 1 : $clog2(els_p);

  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [ptr_w_lp-1:0] ptr_one_lp  = ptr_w_lp'(1);
  localparam logic [cnt_w_lp-1:0] els_cnt_lp  = cnt_w_lp'(els_p);
  localparam logic [cnt_w_lp-1:0] cnt_one_lp  = cnt_w_lp'(1);

  // Valid is ignored during reset so that ready_o stays low.
  logic                 v_eff;
  logic                 ready;
  logic [num_out_p-1:0] lane_rdy;
  logic [num_out_p-1:0] enq;
  logic [num_out_p-1:0] sent_q;
  logic [num_out_p-1:0] sent_d;

  assign v_eff   = v_i & ~reset_i;
  assign ready_o = ready;

  // ---------------------------------------------------------------------------
  // Scatter control: decides which lanes are written this cycle and whether
  // the beat retires.
  // ---------------------------------------------------------------------------
  always_comb begin
    enq    = '0;
    ready  = 1'b0;
    sent_d = sent_q;
    if (decoupled_p) begin
      // A lane takes the beat once. It may do so in any cycle while the beat
      // is presented. The beat retires when every masked lane is already
      // covered, or is covered by this cycle's write.
      enq    = {num_out_p{v_eff}} & mask_i & ~sent_q & lane_rdy;
      ready  = v_eff & (&(~mask_i | sent_q | enq));
      sent_d = ready ? '0 : (sent_q | enq);
    end else begin
      // All-or-nothing: a single lane that cannot accept holds back the beat.
      // An empty mask retires at once and writes nothing.
      ready  = v_eff & (&(~mask_i | lane_rdy));
      enq    = {num_out_p{ready}} & mask_i;
      sent_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sent_q <= '0;
    end else begin
      sent_q <= sent_d;
    end
  end

  assign pending_o = decoupled_p ? sent_q : '0;

  // ---------------------------------------------------------------------------
  // Per-lane FIFOs. Each lane has its own storage, pointers and counter.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < num_out_p; g++) begin : g_lane
    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_q;
    logic [ptr_w_lp-1:0] wr_ptr_d;
    logic [ptr_w_lp-1:0] rd_ptr_q;
    logic [ptr_w_lp-1:0] rd_ptr_d;
    logic [cnt_w_lp-1:0] count_q;
    logic [cnt_w_lp-1:0] count_d;
    logic                deq;

    assign v_o[g]                           = (count_q != '0);
    assign deq                              = yumi_i[g] & v_o[g];
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign lane_rdy[g]                      = (count_q < els_cnt_lp) | yumi_i[g];
    assign data_o[g*width_p +: width_p]     = mem_q[rd_ptr_q];
    assign count_o[g*cnt_w_lp +: cnt_w_lp]  = count_q;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq[g]) begin
        wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_one_lp;
      end
      if (deq) begin
        rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_one_lp;
      end
      if (enq[g] & ~deq) begin
        count_d = count_q + cnt_one_lp;
      end else if (~enq[g] & deq) begin
        count_d = count_q - cnt_one_lp;
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Payload storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_i) begin
      if (enq[g]) begin
        mem_q[wr_ptr_q] <= data_i[g*width_p +: width_p];
      end
    end

    a_count_range : assert property (@(posedge clk_i) disable iff (reset_i)
      count_q <= els_cnt_lp)
      else $error("outputs_scatter_mcast: lane %0d count above depth", g);
  end

  // ---------------------------------------------------------------------------
  // Interface protocol checks
  // ---------------------------------------------------------------------------
  a_yumi_legal : assert property (@(posedge clk_i) disable iff (reset_i)
    ~|(yumi_i & ~v_o))
    else $error("outputs_scatter_mcast: yumi_i on a lane with v_o low");

  a_beat_stable : assert property (@(posedge clk_i) disable iff (reset_i)
    (v_i && !ready_o) |=> ($stable(data_i) && $stable(mask_i)))
    else $error("outputs_scatter_mcast: data_i/mask_i changed before accept");

endmodule

// File: tb/tb_outputs_scatter_mcast.sv
module tb_outputs_scatter_mcast;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int E  = 2;
  localparam int CW = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Lockstep instance signals
  logic           l_v;
  logic [N*W-1:0] l_data;
  logic [N-1:0]   l_mask;
  logic           l_ready;
  logic [N-1:0]   l_vo;
  logic [N*W-1:0] l_data_o;
  logic [N-1:0]   l_yumi;
  logic [N*CW-1:0] l_count;
  logic [N-1:0]   l_pend;

  // Decoupled instance signals
  logic           d_v;
  logic [N*W-1:0] d_data;
  logic [N-1:0]   d_mask;
  logic           d_ready;
  logic [N-1:0]   d_vo;
  logic [N*W-1:0] d_data_o;
  logic [N-1:0]   d_yumi;
  logic [N*CW-1:0] d_count;
  logic [N-1:0]   d_pend;

  outputs_scatter_mcast #(.width_p(W), .num_out_p(N), .els_p(E), .decoupled_p(1'b0)) u_lock (
    .clk_i(clk), .reset_i(rst), .v_i(l_v), .data_i(l_data), .mask_i(l_mask),
    .ready_o(l_ready), .v_o(l_vo), .data_o(l_data_o), .yumi_i(l_yumi),
    .count_o(l_count), .pending_o(l_pend)
  );

  outputs_scatter_mcast #(.width_p(W), .num_out_p(N), .els_p(E), .decoupled_p(1'b1)) u_dec (
    .clk_i(clk), .reset_i(rst), .v_i(d_v), .data_i(d_data), .mask_i(d_mask),
    .ready_o(d_ready), .v_o(d_vo), .data_o(d_data_o), .yumi_i(d_yumi),
    .count_o(d_count), .pending_o(d_pend)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: one expected queue per lane per instance
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_l_q [N][$];
  logic [W-1:0] exp_d_q [N][$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic l_push(input logic [N*W-1:0] data, input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) if (mask[i]) exp_l_q[i].push_back(data[i*W +: W]);
  endtask

  task automatic d_push(input logic [N*W-1:0] data, input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) if (mask[i]) exp_d_q[i].push_back(data[i*W +: W]);
  endtask

  // Compare the heads of the selected lanes against the scoreboard and raise
  // yumi for them; the caller advances the clock.
  task automatic l_pop(input logic [N-1:0] lanes);
    for (int i = 0; i < N; i++) begin
      if (lanes[i]) begin
        logic [W-1:0] e;
        e = exp_l_q[i].pop_front();
        check($sformatf("l_vo_lane%0d", i), 32'(l_vo[i]), 32'd1);
        check($sformatf("l_head_lane%0d", i), 32'(l_data_o[i*W +: W]), 32'(e));
        l_yumi[i] = l_vo[i];
      end
    end
  endtask

  task automatic d_pop(input logic [N-1:0] lanes);
    for (int i = 0; i < N; i++) begin
      if (lanes[i]) begin
        logic [W-1:0] e;
        e = exp_d_q[i].pop_front();
        check($sformatf("d_vo_lane%0d", i), 32'(d_vo[i]), 32'd1);
        check($sformatf("d_head_lane%0d", i), 32'(d_data_o[i*W +: W]), 32'(e));
        d_yumi[i] = d_vo[i];
      end
    end
  endtask

  task automatic l_drain();
    int guard = 0;
    logic [N-1:0] sel;
    do begin
      sel = '0;
      for (int i = 0; i < N; i++) if (exp_l_q[i].size() > 0) sel[i] = 1'b1;
      if (sel != '0) begin
        l_pop(sel);
        tick();
        l_yumi = '0;
      end
      guard++;
    end while (sel != '0 && guard < 16);
    check("l_drain_done", 32'(sel), 32'd0);
  endtask

  task automatic d_drain();
    int guard = 0;
    logic [N-1:0] sel;
    do begin
      sel = '0;
      for (int i = 0; i < N; i++) if (exp_d_q[i].size() > 0) sel[i] = 1'b1;
      if (sel != '0) begin
        d_pop(sel);
        tick();
        d_yumi = '0;
      end
      guard++;
    end while (sel != '0 && guard < 16);
    check("d_drain_done", 32'(sel), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    l_v = 1'b1; l_data = '0; l_mask = 4'hF; l_yumi = '0;
    d_v = 1'b1; d_data = '0; d_mask = 4'hF; d_yumi = '0;
    tick();
    tick();
    check("rst_l_ready", 32'(l_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_l_vo", 32'(l_vo), 32'd0);
    check("rst_l_count", 32'(l_count), 32'd0);
    check("rst_d_count", 32'(d_count), 32'd0);
    check("rst_d_pend", 32'(d_pend), 32'd0);
    l_v = 1'b0; d_v = 1'b0; rst = 1'b0;
    tick();

    // Lockstep broadcast: two beats fill every lane, the third is refused.
    l_data = 32'hA3A2A1A0; l_mask = 4'hF; l_v = 1'b1;
    settle();
    check("l_bcast_rdy1", 32'(l_ready), 32'd1);
    l_push(l_data, l_mask);
    tick();
    check("l_bcast_vo", 32'(l_vo), 32'hF);
    check("l_bcast_cnt1", 32'(l_count), 32'h55);
    l_data = 32'hA7A6A5A4;
    settle();
    check("l_bcast_rdy2", 32'(l_ready), 32'd1);
    l_push(l_data, l_mask);
    tick();
    check("l_bcast_cnt2", 32'(l_count), 32'hAA);
    l_data = 32'hABAAA9A8;
    settle();
    check("l_full_rdy", 32'(l_ready), 32'd0);

    // Lockstep stall: empty lanes 0,1,3 while lane 2 stays full.
    for (int k = 0; k < 2; k++) begin
      l_pop(4'b1011);
      settle();
      check("l_stall_rdy", 32'(l_ready), 32'd0);
      tick();
      l_yumi = '0;
    end
    check("l_stall_cnt", 32'(l_count), 32'h20);
    l_pop(4'b0100);
    settle();
    check("l_stall_release", 32'(l_ready), 32'd1);
    l_push(l_data, l_mask);
    tick();
    l_yumi = '0; l_v = 1'b0;
    check("l_release_cnt", 32'(l_count), 32'h65);
    l_drain();
    check("l_drained_cnt", 32'(l_count), 32'd0);
    settle();
    check("l_idle_rdy", 32'(l_ready), 32'd0);

    // Multicast to lanes 0 and 2, then an empty-mask drop beat.
    l_data = 32'hC3C2C1C0; l_mask = 4'b0101; l_v = 1'b1;
    settle();
    check("l_mcast_rdy", 32'(l_ready), 32'd1);
    l_push(l_data, l_mask);
    tick();
    check("l_mcast_cnt", 32'(l_count), 32'h11);
    l_mask = 4'b0000; l_data = 32'h5A5A5A5A;
    settle();
    check("l_drop_rdy", 32'(l_ready), 32'd1);
    tick();
    check("l_drop_cnt", 32'(l_count), 32'h11);

    // Full-pass on lane 0: enqueue and dequeue in one cycle at full depth.
    l_mask = 4'b0001; l_data = 32'h000000D0;
    settle();
    check("l_fill_rdy", 32'(l_ready), 32'd1);
    l_push(l_data, l_mask);
    tick();
    check("l_fill_cnt", 32'(l_count), 32'h12);
    l_data = 32'h000000E0;
    l_pop(4'b0001);
    settle();
    check("l_pass_rdy", 32'(l_ready), 32'd1);
    l_push(l_data, l_mask);
    tick();
    l_yumi = '0; l_v = 1'b0;
    check("l_pass_cnt", 32'(l_count), 32'h12);
    l_drain();
    check("l_end_cnt", 32'(l_count), 32'd0);

    // Decoupled: fill lane 3, then a broadcast beat delivers partially.
    d_mask = 4'b1000; d_data = 32'h30000000; d_v = 1'b1;
    settle();
    check("d_fill_rdy1", 32'(d_ready), 32'd1);
    d_push(d_data, d_mask);
    tick();
    d_data = 32'h31000000;
    settle();
    check("d_fill_rdy2", 32'(d_ready), 32'd1);
    d_push(d_data, d_mask);
    tick();
    check("d_fill_cnt", 32'(d_count), 32'h80);
    d_mask = 4'hF; d_data = 32'hB3B2B1B0;
    settle();
    check("d_part_rdy0", 32'(d_ready), 32'd0);
    d_push(d_data, 4'b0111);
    tick();
    check("d_part_pend", 32'(d_pend), 32'h7);
    check("d_part_rdy1", 32'(d_ready), 32'd0);
    check("d_part_cnt", 32'(d_count), 32'h95);
    d_pop(4'b1000);
    settle();
    check("d_part_done_rdy", 32'(d_ready), 32'd1);
    d_push(d_data, 4'b1000);
    tick();
    d_yumi = '0; d_v = 1'b0;
    check("d_part_pend0", 32'(d_pend), 32'h0);
    check("d_part_cnt2", 32'(d_count), 32'h95);
    d_drain();
    check("d_part_end_cnt", 32'(d_count), 32'd0);

    // Decoupled reset mid-beat: lanes 2,3 full, beat delivers to lanes 0,1.
    d_mask = 4'b1100; d_data = 32'hC1C10000; d_v = 1'b1;
    settle();
    check("d_pre_rdy1", 32'(d_ready), 32'd1);
    tick();
    d_data = 32'hC2C20000;
    settle();
    check("d_pre_rdy2", 32'(d_ready), 32'd1);
    tick();
    d_mask = 4'hF; d_data = 32'hF3F2F1F0;
    settle();
    check("d_pre_rdy3", 32'(d_ready), 32'd0);
    tick();
    check("d_pre_pend", 32'(d_pend), 32'h3);
    rst = 1'b1;
    settle();
    check("d_rst_rdy", 32'(d_ready), 32'd0);
    tick();
    rst = 1'b0;
    check("d_rst_pend", 32'(d_pend), 32'h0);
    check("d_rst_vo", 32'(d_vo), 32'h0);
    check("d_rst_cnt", 32'(d_count), 32'h0);
    settle();
    check("d_replay_rdy", 32'(d_ready), 32'd1);
    d_push(d_data, d_mask);
    tick();
    d_v = 1'b0;
    check("d_replay_cnt", 32'(d_count), 32'h55);
    check("d_replay_vo", 32'(d_vo), 32'hF);
    d_drain();
    check("d_end_cnt", 32'(d_count), 32'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
